// File: rtl/idex_pkg.sv
// ---------------------------------------------------------------------------
// idex_pkg
//   Shared definitions for the ID/EX operand latch.
//   - Default operand width and register address width.
//   - Upper bounds for the snoop selector's fixed-width argument vectors.
//   - snoop_sel(): fixed-priority writeback match that returns {hit, data}.
// ---------------------------------------------------------------------------
package idex_pkg;

  localparam int IDEX_XLEN = 64;
  localparam int IDEX_AW   = 5;

  // A package function cannot take the instantiating module's parameters.
  // The selector therefore works on vectors sized for the largest supported
  // configuration, and callers zero-extend into them. Zero-padded write
  // enables never match, so the padding cannot produce a hit.
  localparam int SNOOP_MAX_XLEN = 128;
  localparam int SNOOP_MAX_NWB  = 8;
  localparam int SNOOP_MAX_AW   = 8;

  typedef struct packed {
    logic                      hit;
    logic [SNOOP_MAX_XLEN-1:0] data;
  } snoop_t;

  // Returns the data of the lowest-index enabled port whose address matches.
  // Register 0 is hard-wired, so a match on address 0 is never reported.
  // The scan runs from the highest index down so that lower indices
  // overwrite the result and win.
  function automatic snoop_t snoop_sel(
    input logic [SNOOP_MAX_AW-1:0]                addr,
    input logic [SNOOP_MAX_NWB-1:0]               we,
    input logic [SNOOP_MAX_NWB*SNOOP_MAX_AW-1:0]  waddr,
    input logic [SNOOP_MAX_NWB*SNOOP_MAX_XLEN-1:0] wdata
  );
    snoop_t res;
    res = '0;
    for (int k = SNOOP_MAX_NWB - 1; k >= 0; k--) begin
      if (we[k] && (waddr[k*SNOOP_MAX_AW +: SNOOP_MAX_AW] == addr) &&
          (addr != '0)) begin
        res.hit  = 1'b1;
        res.data = wdata[k*SNOOP_MAX_XLEN +: SNOOP_MAX_XLEN];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/idex_operand_latch_if.sv
// ---------------------------------------------------------------------------
// idex_operand_latch_if
//   Bundles the ID-stage operand bus, the writeback snoop ports, the EX-stage
//   operand outputs and the stall/flush controls of idex_operand_latch.
//   Modports:
//     master - pipeline side: drives stall, flush, id_*, wb_*; reads ex_*
//     slave  - the latch:     reads stall, flush, id_*, wb_*; drives ex_*
//   Signals:
//     stall, flush        EX hold / EX squash
//     id_valid            ID stage holds a real instruction
//     id_rs_addr/data     operand i at [i*AW +: AW] / [i*XLEN +: XLEN]
//     wb_we/addr/data     NWB writeback ports, index 0 highest priority
//     ex_valid            EX stage holds a real instruction
//     ex_rs_addr/data     latched (possibly refreshed) operands
//     ex_rs_captured      operand i refreshed by a snoop since its load
//     ex_stall_cnt        saturating count of consecutive stall cycles
// ---------------------------------------------------------------------------
interface idex_operand_latch_if #(
  parameter int XLEN   = 64,
  parameter int NSRC   = 2,
  parameter int NWB    = 2,
  parameter int AW     = 5,
  parameter int SCNT_W = 4
);

  logic                 stall;
  logic                 flush;
  logic                 id_valid;
  logic [NSRC*AW-1:0]   id_rs_addr;
  logic [NSRC*XLEN-1:0] id_rs_data;
  logic [NWB-1:0]       wb_we;
  logic [NWB*AW-1:0]    wb_addr;
  logic [NWB*XLEN-1:0]  wb_data;
  logic                 ex_valid;
  logic [NSRC*AW-1:0]   ex_rs_addr;
  logic [NSRC*XLEN-1:0] ex_rs_data;
  logic [NSRC-1:0]      ex_rs_captured;
  logic [SCNT_W-1:0]    ex_stall_cnt;

  modport master (
    output stall, flush, id_valid, id_rs_addr, id_rs_data,
           wb_we, wb_addr, wb_data,
    input  ex_valid, ex_rs_addr, ex_rs_data, ex_rs_captured, ex_stall_cnt
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_addr, id_rs_data,
           wb_we, wb_addr, wb_data,
    output ex_valid, ex_rs_addr, ex_rs_data, ex_rs_captured, ex_stall_cnt
  );

endinterface

// File: rtl/idex_snoop_mux.sv
// ---------------------------------------------------------------------------
// idex_snoop_mux
//   NWB-way fixed-priority writeback match for one operand.
//   Ports:
//     en     in  1         qualifies the match (instruction is valid)
//     addr   in  AW        operand register address
//     we     in  NWB       writeback enables
//     waddr  in  NWB*AW    writeback addresses
//     wdata  in  NWB*XLEN  writeback data
//     hit    out 1         some enabled port writes addr (addr != 0)
//     data   out XLEN      data of the lowest-index matching port
//   Supports XLEN <= 128, NWB <= 8, AW <= 8.
// ---------------------------------------------------------------------------
module idex_snoop_mux
  import idex_pkg::*;
#(
  parameter int XLEN = IDEX_XLEN,
  parameter int NWB  = 2,
  parameter int AW   = IDEX_AW
) (
  input  logic                en,
  input  logic [AW-1:0]       addr,
  input  logic [NWB-1:0]      we,
  input  logic [NWB*AW-1:0]   waddr,
  input  logic [NWB*XLEN-1:0] wdata,
  output logic                hit,
  output logic [XLEN-1:0]     data
);

  logic [SNOOP_MAX_AW-1:0]                addr_pad;
  logic [SNOOP_MAX_NWB-1:0]               we_pad;
  logic [SNOOP_MAX_NWB*SNOOP_MAX_AW-1:0]  waddr_pad;
  logic [SNOOP_MAX_NWB*SNOOP_MAX_XLEN-1:0] wdata_pad;
  snoop_t                                 sel;

  // Widen into the selector's fixed-size vectors. Gating the enables with
  // en keeps invalid instructions from ever reporting a hit.
  always_comb begin
    addr_pad  = SNOOP_MAX_AW'(addr);
    we_pad    = '0;
    waddr_pad = '0;
    wdata_pad = '0;
    for (int k = 0; k < NWB; k++) begin
      we_pad[k] = we[k] & en;
      waddr_pad[k*SNOOP_MAX_AW +: SNOOP_MAX_AW] =
        SNOOP_MAX_AW'(waddr[k*AW +: AW]);
      wdata_pad[k*SNOOP_MAX_XLEN +: SNOOP_MAX_XLEN] =
        SNOOP_MAX_XLEN'(wdata[k*XLEN +: XLEN]);
    end
    sel = snoop_sel(addr_pad, we_pad, waddr_pad, wdata_pad);
  end

  assign hit  = sel.hit;
  assign data = sel.data[XLEN-1:0];

  // Upper selector bits beyond XLEN are always zero and intentionally dropped.
  logic unused_sel;
  assign unused_sel = ^sel.data;

endmodule

// File: rtl/idex_operand_latch.sv
// ---------------------------------------------------------------------------
// idex_operand_latch
//   ID/EX pipeline register for NSRC source operands. Operands are held
//   across EX stalls and refreshed from the writeback ports while held, so
//   the EX forwarding muxes never see a stale value for a stalled
//   instruction. Optionally the same match is applied on the load cycle for
//   register files without write-before-read.
//   Ports:
//     clk   in  clock
//     rstn  in  asynchronous active-low reset
//     bus   slave modport of idex_operand_latch_if (stall, flush, id_*,
//           wb_* in; ex_valid, ex_rs_addr, ex_rs_data, ex_rs_captured,
//           ex_stall_cnt out). All outputs are registered.
// ---------------------------------------------------------------------------
module idex_operand_latch
  import idex_pkg::*;
#(
  parameter int XLEN        = IDEX_XLEN,
  parameter int NSRC        = 2,
  parameter int NWB         = 2,
  parameter int AW          = IDEX_AW,
  parameter bit LOAD_BYPASS = 1'b1,
  parameter int SCNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  idex_operand_latch_if.slave  bus
);

  logic                 ex_valid_q;
  logic [NSRC*AW-1:0]   ex_addr_q;
  logic [NSRC*XLEN-1:0] ex_data_q;
  logic [NSRC-1:0]      ex_cap_q;
  logic [SCNT_W-1:0]    ex_cnt_q;

  logic [NSRC-1:0]      snoop_hit;
  logic [NSRC*XLEN-1:0] snoop_data;

  // One matcher per operand serves both the load and the hold cycle: while
  // stalled it compares against the latched address qualified by ex_valid,
  // otherwise against the incoming ID address qualified by id_valid.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [AW-1:0] sel_addr;
    logic          sel_en;

    assign sel_addr = bus.stall ? ex_addr_q[i*AW +: AW]
                                : bus.id_rs_addr[i*AW +: AW];
    assign sel_en   = bus.stall ? ex_valid_q : bus.id_valid;

    idex_snoop_mux #(
      .XLEN (XLEN),
      .NWB  (NWB),
      .AW   (AW)
    ) u_snoop (
      .en    (sel_en),
      .addr  (sel_addr),
      .we    (bus.wb_we),
      .waddr (bus.wb_addr),
      .wdata (bus.wb_data),
      .hit   (snoop_hit[i]),
      .data  (snoop_data[i*XLEN +: XLEN])
    );
  end

  // Flush beats load beats hold. Captured flags are sticky during a hold
  // and only cleared by a plain load, flush or reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid_q <= 1'b0;
      ex_addr_q  <= '0;
      ex_data_q  <= '0;
      ex_cap_q   <= '0;
      ex_cnt_q   <= '0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
      ex_addr_q  <= '0;
      ex_data_q  <= '0;
      ex_cap_q   <= '0;
      ex_cnt_q   <= '0;
    end else if (!bus.stall) begin
      ex_valid_q <= bus.id_valid;
      ex_addr_q  <= bus.id_rs_addr;
      ex_cnt_q   <= '0;
      for (int i = 0; i < NSRC; i++) begin
        if (LOAD_BYPASS && snoop_hit[i]) begin
          ex_data_q[i*XLEN +: XLEN] <= snoop_data[i*XLEN +: XLEN];
          ex_cap_q[i]               <= 1'b1;
        end else begin
          ex_data_q[i*XLEN +: XLEN] <= bus.id_rs_data[i*XLEN +: XLEN];
          ex_cap_q[i]               <= 1'b0;
        end
      end
    end else begin
      if (ex_cnt_q != '1) begin
        ex_cnt_q <= ex_cnt_q + SCNT_W'(1);
      end
      for (int i = 0; i < NSRC; i++) begin
        if (snoop_hit[i]) begin
          ex_data_q[i*XLEN +: XLEN] <= snoop_data[i*XLEN +: XLEN];
          ex_cap_q[i]               <= 1'b1;
        end
      end
    end
  end

  assign bus.ex_valid       = ex_valid_q;
  assign bus.ex_rs_addr     = ex_addr_q;
  assign bus.ex_rs_data     = ex_data_q;
  assign bus.ex_rs_captured = ex_cap_q;
  assign bus.ex_stall_cnt   = ex_cnt_q;

endmodule

// File: doc/idex_operand_latch.md
Name: idex_operand_latch

Overview:
- Parametrised ID/EX pipeline register for NSRC source operands of width XLEN.
- Holds operands across EX stalls and refreshes any held operand that a writeback port writes while the stall lasts, matching on register address; no external forwarding code is needed.
- Sits between the ID-stage register-file read and the EX-stage forwarding muxes.
- Adds address tracking, a valid bit, multi-port writeback snoop, load-time bypass, per-operand capture flags and a saturating stall counter.

Parameters:
- XLEN, 64, operand data width
- NSRC, 2, number of source operands (1..4)
- NWB, 2, number of writeback snoop ports; index 0 has highest priority (youngest producer)
- AW, 5, register address width
- LOAD_BYPASS, 1, 1 = apply the writeback match also on the load cycle (register file without write-before-read)
- SCNT_W, 4, stall counter width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- stall  in  1  hold the EX stage this cycle
- flush  in  1  synchronous squash of the EX stage
- id_valid  in  1  ID stage holds a real instruction
- id_rs_addr  in  NSRC*AW  operand addresses, operand i at [i*AW +: AW]
- id_rs_data  in  NSRC*XLEN  register-file read data
- wb_we  in  NWB  writeback enables
- wb_addr  in  NWB*AW  writeback destination addresses
- wb_data  in  NWB*XLEN  writeback data
- ex_valid  out  1  EX stage holds a real instruction
- ex_rs_addr  out  NSRC*AW  latched addresses
- ex_rs_data  out  NSRC*XLEN  latched, possibly refreshed, operands
- ex_rs_captured  out  NSRC  operand i was refreshed by a snoop since its load
- ex_stall_cnt  out  SCNT_W  consecutive stall cycles of the current EX instruction, saturating

Behaviour:
- Reset (rstn=0, asynchronous): ex_valid=0, ex_rs_addr=0, ex_rs_data=0, ex_rs_captured=0, ex_stall_cnt=0.
- Priority per clock edge: flush > load (stall=0) > hold/snoop (stall=1).
- Flush: all outputs return to their reset values. Flush wins over stall and over any snoop hit in the same cycle.
- Load (stall=0, flush=0):
  - ex_valid <= id_valid; ex_rs_addr <= id_rs_addr; ex_stall_cnt <= 0.
  - ex_rs_data[i] <= id_rs_data[i], or the snoop value when LOAD_BYPASS=1 and a snoop hit exists on id_rs_addr[i].
  - ex_rs_captured[i] <= 0 on a plain load, 1 on a load bypass.
  - Latency: one cycle.
- Hold (stall=1, flush=0):
  - ex_valid and ex_rs_addr hold.
  - ex_stall_cnt increments and saturates at 2^SCNT_W-1.
  - For each operand i with a snoop hit on ex_rs_addr[i]: ex_rs_data[i] <= winning wb_data and ex_rs_captured[i] <= 1. Otherwise both hold.
- Snoop hit definition: wb_we[k]=1, wb_addr[k]==addr, addr!=0, and ex_valid=1 (in hold) or id_valid=1 (in load).
- Several ports matching the same address: the lowest index k wins.
- Different operands sharing one address are refreshed identically in the same cycle.
- Address 0 is never captured; x0 stays the value latched at load.
- Captured flags are sticky until the next load or flush.
- Snoops during hold with ex_valid=0 are ignored and data holds.
- Reset mid-stall clears everything immediately. Deasserting rstn takes effect at the next edge only.
- No combinational path from inputs to outputs.

Decomposition:
- Package idex_pkg holds default XLEN/AW and the function snoop_sel(addr, we, waddr, wdata), which returns {hit, data} under fixed-priority selection.
- One sub-module, idex_snoop_mux (NWB-way priority match for one operand), instantiated NSRC times by a generate loop.

Test Plan:
- Load path: stall=0, id_valid=1, rs1=x5/0xA, rs2=x6/0xB, no wb -> next cycle ex_valid=1, ex_rs_data={0xB,0xA}, captured=00, stall_cnt=0.
- Stall snoop and priority: hold x5; assert wb0 and wb1 both x5, data 0x111 and 0x222 in stall cycle 2 -> ex_rs1=0x111, captured[0]=1, rs2 unchanged, stall_cnt=2.
- x0 and aliasing: rs1=rs2=x0, then wb x0=0xFF during stall -> data unchanged, captured=00. Repeat with rs1=rs2=x7 and wb x7=0x77 -> both operands 0x77, captured=11.
- Flush priority: stall=1, flush=1 and a wb hit in the same cycle -> all outputs 0 next cycle.
- Load bypass: LOAD_BYPASS=1, stall=0, id rs1=x9/0x1, wb1 x9=0x99 -> ex_rs1=0x99, captured[0]=1. With LOAD_BYPASS=0 -> 0x1, captured[0]=0.
- Saturation and reset: stall held for 20 cycles with SCNT_W=4 -> stall_cnt stays at 15; pulse rstn low mid-stall -> outputs 0 asynchronously.
